// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control path: FSM states, opcodes,
// alu_op / alu_src_b / pc_source encodings and the opcode class vector.
// ALUControl imports the same alu_op constants from here.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecute,
    StAluWb,
    StBranch,
    StJump
  } state_e;

  // Opcodes
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // alu_op encodings
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBBrOff = 2'b11;

  // pc_source encodings
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // One-hot instruction class
  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps the opcode field to a one-hot class.
// JAL is recognised only when MULTICYCLE_JAL_EN is defined; otherwise it is
// classed as illegal.
module opcode_class
  import multicycle_pkg::*;
#(
  parameter int unsigned opcodeWidth = 7
) (
  input  logic [opcodeWidth-1:0] opcode,
  output op_class_t              op_class
);

  // Decode the opcode into exactly one class bit
  always_comb begin
    op_class = '0;
    case (opcode)
      opcodeWidth'(OpRtype):  op_class.rtype  = 1'b1;
      opcodeWidth'(OpLoad):   op_class.load   = 1'b1;
      opcodeWidth'(OpStore):  op_class.store  = 1'b1;
      opcodeWidth'(OpBranch): op_class.branch = 1'b1;
`ifdef MULTICYCLE_JAL_EN
      opcodeWidth'(OpJal):    op_class.jump   = 1'b1;
`endif
      default:                op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath. Steps each instruction through
// fetch, decode, execute, memory and write-back, and drives the datapath
// enables/muxes. Memory accesses are paced by mem_ready.
// Optional feature macro: MULTICYCLE_JAL_EN enables JAL decode and the JUMP state.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned aluOpWidth  = 2,
  parameter int unsigned opcodeWidth = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [opcodeWidth-1:0] opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [aluOpWidth-1:0]  alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op
);

  state_e    state_q;
  op_class_t op_class;
  logic      dec_illegal;
  logic [1:0] alu_op_int;

  opcode_class #(
    .opcodeWidth (opcodeWidth)
  ) u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

`ifdef MULTICYCLE_JAL_EN
  assign dec_illegal = op_class.illegal;
`else
  // Without JAL support a jump class can never be legal.
  assign dec_illegal = op_class.illegal | op_class.jump;
`endif

  assign alu_op = aluOpWidth'(alu_op_int);

  // State register and next-state sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          if (op_class.load || op_class.store) state_q <= StMemAddr;
          else if (op_class.rtype)             state_q <= StExecute;
          else if (op_class.branch)            state_q <= StBranch;
`ifdef MULTICYCLE_JAL_EN
          else if (op_class.jump)              state_q <= StJump;
`endif
          else                                 state_q <= StFetch;
        end
        StMemAddr: begin
          if (op_class.load)       state_q <= StMemRead;
          else if (op_class.store) state_q <= StMemWrite;
          else                     state_q <= StFetch;
        end
        StMemRead: begin
          if (mem_ready) state_q <= StMemWb;
        end
        StMemWb:    state_q <= StFetch;
        StMemWrite: begin
          if (mem_ready) state_q <= StFetch;
        end
        StExecute:  state_q <= StAluWb;
        StAluWb:    state_q <= StFetch;
        StBranch:   state_q <= StFetch;
`ifdef MULTICYCLE_JAL_EN
        StJump:     state_q <= StFetch;
`endif
        default:    state_q <= StFetch;
      endcase
    end
  end

  // Output decode from state; mem_ready and zero gate the PC/IR strobes.
  // Reset forces every output low, overriding the FETCH decode.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    alu_op_int = AluOpAdd;
    pc_source  = PcSrcAlu;
    illegal_op = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SrcBFour;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b  = SrcBBrOff;
          illegal_op = dec_illegal;
        end
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        StMemRead: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWrite: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        StExecute: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SrcBReg;
          alu_op_int = AluOpFunct;
        end
        StAluWb: begin
          reg_write = 1'b1;
        end
        StBranch: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SrcBReg;
          alu_op_int = AluOpSub;
          pc_source  = PcSrcAluOut;
          pc_write   = zero;
        end
`ifdef MULTICYCLE_JAL_EN
        StJump: begin
          pc_source = PcSrcJump;
          pc_write  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level step-list
// model predicts every output on every cycle under random stimulus, plus a few
// directed instructions with literal cycle counts and a mid-store reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  logic [14:0] dut_vec;
  assign dut_vec = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

`ifdef MULTICYCLE_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, BAD = 7'b1111111;

  // Instruction steps
  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
  localparam int SEX = 6, SAWB = 7, SBR = 8, SJ = 9;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pos 0 = fetch, 1 = decode, 2.. = class-specific step list
  int         pos = 0;
  logic [6:0] inst_op = '0;
  int         cur_zero = -1;
  int         cur_stall = 0;
  bit         rnd_mr = 1'b0;
  bit         hold_mw = 1'b0;
  int         cyc = 0;
  int         last_ir = -1;
  int         gaps[$];
  logic [6:0] dq_op[$];
  int         dq_zero[$];
  int         dq_stall[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // 0 R, 1 load, 2 store, 3 branch, 4 jump, 5 illegal
  function automatic int cls(input logic [6:0] op);
    case (op)
      R:       return 0;
      LW:      return 1;
      SW:      return 2;
      BEQ:     return 3;
      JAL:     return JalEn ? 4 : 5;
      default: return 5;
    endcase
  endfunction

  function automatic int seq_len(input logic [6:0] op);
    case (cls(op))
      0: return 2;
      1: return 3;
      2: return 2;
      3: return 1;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int seq_at(input logic [6:0] op, input int k);
    case (cls(op))
      0: return (k == 0) ? SEX : SAWB;
      1: return (k == 0) ? SMA : ((k == 1) ? SMR : SMWB);
      2: return (k == 0) ? SMA : SMW;
      3: return SBR;
      4: return SJ;
      default: return SF;
    endcase
  endfunction

  function automatic int cpi(input logic [6:0] op);
    return 2 + seq_len(op);
  endfunction

  function automatic int cur_step();
    if (pos == 0) return SF;
    if (pos == 1) return SD;
    return seq_at(inst_op, pos - 2);
  endfunction

  function automatic logic [14:0] exp_vec(input int st, input logic mr, input logic z,
                                          input logic [6:0] op);
    logic pcw, irw, iod, mrd, mwr, rw, m2r, sa, ill;
    logic [1:0] sb, ao, ps;
    {pcw, irw, iod, mrd, mwr, rw, m2r, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      SF:   begin mrd = 1'b1; sb = 2'b01; pcw = mr; irw = mr; end
      SD:   begin sb = 2'b11; ill = (cls(op) == 5); end
      SMA:  begin sa = 1'b1; sb = 2'b10; end
      SMR:  begin iod = 1'b1; mrd = 1'b1; end
      SMWB: begin rw = 1'b1; m2r = 1'b1; end
      SMW:  begin iod = 1'b1; mwr = 1'b1; end
      SEX:  begin sa = 1'b1; ao = 2'b10; end
      SAWB: begin rw = 1'b1; end
      SBR:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pcw = z; end
      SJ:   begin ps = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {pcw, irw, iod, mrd, mwr, rw, m2r, sa, sb, ao, ps, ill};
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 5))
      0: return R;
      1: return LW;
      2: return SW;
      3: return BEQ;
      4: return JAL;
      default: return 7'($urandom);
    endcase
  endfunction

  // One clock: drive inputs, compare at negedge, advance model at posedge
  task automatic step_cycle();
    int st;
    st = cur_step();
    if (st == SD) begin
      if (dq_op.size() > 0) begin
        opcode    = dq_op.pop_front();
        cur_zero  = dq_zero.pop_front();
        cur_stall = dq_stall.pop_front();
      end else begin
        opcode    = rand_op();
        cur_zero  = -1;
        cur_stall = 0;
      end
    end else if (st != SMA) begin
      opcode = 7'($urandom);  // opcode is a don't-care here
    end
    if ((st == SMR || st == SMW) && cur_stall > 0) begin
      mem_ready = 1'b0;
      cur_stall--;
    end else if (hold_mw && st == SMW) begin
      mem_ready = 1'b0;
    end else if (rnd_mr) begin
      mem_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mem_ready = 1'b1;
    end
    zero = (cur_zero < 0) ? 1'($urandom) : 1'(cur_zero);
    @(negedge clk);
    check($sformatf("cyc%0d_step%0d_outputs", cyc, st), 32'(dut_vec),
          32'(exp_vec(st, mem_ready, zero, opcode)));
    if (ir_write === 1'b1) begin
      if (last_ir >= 0) gaps.push_back(cyc - last_ir);
      last_ir = cyc;
    end
    cyc++;
    @(posedge clk);
    if (!((st == SF || st == SMR || st == SMW) && !mem_ready)) begin
      if (st == SD) inst_op = opcode;
      pos++;
      if (pos >= 2 && (pos - 2) >= seq_len(inst_op)) pos = 0;
    end
    #1;
  endtask

  initial begin
    int exp_gaps[7];
    int i;
    exp_gaps = '{4, 7, 4, 3, 3, 2, (JalEn ? 3 : 2)};

    // Pin the model's cycle counts with mem_ready tied high
    check("cpi_rtype", 32'(cpi(R)), 32'd4);
    check("cpi_lw", 32'(cpi(LW)), 32'd5);
    check("cpi_sw", 32'(cpi(SW)), 32'd4);
    check("cpi_beq", 32'(cpi(BEQ)), 32'd3);
    check("cpi_illegal", 32'(cpi(BAD)), 32'd2);
    check("cpi_jal", 32'(cpi(JAL)), JalEn ? 32'd3 : 32'd2);

    // Reset: all outputs low even with mem_ready high
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = R;
    @(negedge clk);
    check("reset_outputs_0", 32'(dut_vec), 32'd0);
    @(negedge clk);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;

    // Directed: R, LW (2 stalls in MEM_READ), SW, BEQ z=1, BEQ z=0, illegal, JAL
    dq_op    = '{R, LW, SW, BEQ, BEQ, BAD, JAL};
    dq_zero  = '{-1, -1, -1, 1, 0, -1, -1};
    dq_stall = '{0, 2, 0, 0, 0, 0, 0};
    rnd_mr = 1'b0;
    repeat (30) step_cycle();
    check("directed_gap_count_ok", 32'(gaps.size() >= 7), 32'd1);
    for (int k = 0; k < 7; k++) begin
      if (k < gaps.size()) check($sformatf("directed_cycles_%0d", k), 32'(gaps[k]),
                                 32'(exp_gaps[k]));
    end

    // Random instructions, random memory stalls and opcode noise
    rnd_mr = 1'b1;
    repeat (1500) step_cycle();

    // Store interrupted by reset while stalled in MEM_WRITE
    dq_op.push_back(SW); dq_zero.push_back(-1); dq_stall.push_back(0);
    hold_mw = 1'b1;
    i = 0;
    while (i < 80 && !(cur_step() == SMW && dq_op.size() == 0)) begin
      step_cycle();
      i++;
    end
    check("reach_mem_write", 32'(cur_step() == SMW), 32'd1);
    step_cycle();
    mem_ready = 1'b1;
    #2;
    check("mem_write_before_rst", 32'(mem_write), 32'(cur_step() == SMW));
    rst = 1'b1;
    #1;
    check("rst_async_zero", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_zero", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_mw = 1'b0;
    pos = 0;
    mem_ready = 1'b0;
    #1;
    check("fetch_after_rst_mem_read", 32'(mem_read), 32'd1);
    check("fetch_after_rst_no_write", 32'(mem_write), 32'd0);
    check("fetch_after_rst_ir_hold", 32'(ir_write), 32'd0);
    @(posedge clk); #1;
    repeat (200) step_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
